instr_decode: RTL

INSTR_DECODE -- requirements
Module: instr_decode

---
 rtl/instr_decode.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/instr_decode.sv
// Decode stage: decodes fetched words at push time into a 2-entry FIFO of
// decoded bundles, and presents the head entry downstream.
module instr_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  alu_op,
    output logic [4:0]  rs_idx,
    output logic [4:0]  rt_idx,
    output logic [4:0]  wr_idx,
    output logic [15:0] imm16,
    output logic [25:0] target,
    output logic        reg_we,
    output logic        is_jump,
    output logic        illegal,
    output logic [31:0] pc_out,
    output logic [15:0] illegal_count
);

    typedef struct packed {
        logic [5:0]  alu_op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [15:0] imm16;
        logic [25:0] target;
        logic        reg_we;
        logic        is_jump;
        logic        illegal;
        logic [31:0] pc;
    } entry_t;

    function automatic entry_t decode(input logic [31:0] ins, input logic [31:0] pc_i);
        entry_t e;
        e.alu_op  = 6'h3F;
        e.rs      = ins[25:21];
        e.rt      = ins[20:16];
        e.wr      = 5'd0;
        e.imm16   = ins[15:0];
        e.target  = ins[25:0];
        e.reg_we  = 1'b0;
        e.is_jump = 1'b0;
        e.illegal = 1'b1;
        e.pc      = pc_i;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20:   begin e.alu_op = 6'h00; e.illegal = 1'b0; e.wr = ins[15:11]; end
                    6'h22:   begin e.alu_op = 6'h01; e.illegal = 1'b0; e.wr = ins[15:11]; end
                    6'h24:   begin e.alu_op = 6'h02; e.illegal = 1'b0; e.wr = ins[15:11]; end
                    6'h25:   begin e.alu_op = 6'h03; e.illegal = 1'b0; e.wr = ins[15:11]; end
                    6'h26:   begin e.alu_op = 6'h04; e.illegal = 1'b0; e.wr = ins[15:11]; end
                    default: e.illegal = 1'b1;
                endcase
            end
            6'h08:   begin e.alu_op = 6'h10; e.illegal = 1'b0; e.wr = ins[20:16]; end
            6'h02:   begin e.alu_op = 6'h00; e.illegal = 1'b0; e.is_jump = 1'b1; end
            default: e.illegal = 1'b1;
        endcase
        // Writes to r0 are architecturally void, so never raise the write enable.
        e.reg_we = !e.illegal && !e.is_jump && (e.wr != 5'd0);
        return e;
    endfunction

    entry_t     mem_r [2];
    logic       wptr_r;
    logic       rptr_r;
    logic [1:0] count_r;
    logic [15:0] icnt_r;
    entry_t     dec_s;
    entry_t     head_s;
    logic       push_s;
    logic       pop_s;

    assign dec_s     = decode(instr, pc);
    assign in_ready  = (count_r < 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign illegal_count = icnt_r;

    // FIFO storage, pointers and occupancy; flush beats push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wptr_r   <= 1'b0;
            rptr_r   <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wptr_r   <= 1'b0;
            rptr_r   <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[wptr_r] <= dec_s;
                wptr_r        <= ~wptr_r;
            end
            if (pop_s) begin
                rptr_r <= ~rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Saturating count of illegal words that actually entered the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            icnt_r <= 16'd0;
        end else if (push_s && !flush && dec_s.illegal && (icnt_r != 16'hFFFF)) begin
            icnt_r <= icnt_r + 16'd1;
        end else begin
            icnt_r <= icnt_r;
        end
    end

    assign head_s = mem_r[rptr_r];

    // Present the head entry, forced to zero whenever nothing is valid.
    always_comb begin
        alu_op  = 6'h00;
        rs_idx  = 5'd0;
        rt_idx  = 5'd0;
        wr_idx  = 5'd0;
        imm16   = 16'h0000;
        target  = 26'h0;
        reg_we  = 1'b0;
        is_jump = 1'b0;
        illegal = 1'b0;
        pc_out  = 32'h0;
        if (out_valid) begin
            alu_op  = head_s.alu_op;
            rs_idx  = head_s.rs;
            rt_idx  = head_s.rt;
            wr_idx  = head_s.wr;
            imm16   = head_s.imm16;
            target  = head_s.target;
            reg_we  = head_s.reg_we;
            is_jump = head_s.is_jump;
            illegal = head_s.illegal;
            pc_out  = head_s.pc;
        end else begin
            pc_out  = 32'h0;
        end
    end

endmodule
